weight_loader: RTL and testbench

- Sits directly downstream of the APB control registers and directly upstream of the systolic array's weight shift chain.
- Collects one binary weight row per beat from a streaming source into a local buffer.
- On the one-cycle weight_transfer pulse, replays rows 0..last_row into the array, with columns above last_col zero-masked.
- Signals completion with a done pulse.

---
 rtl/bnn_pkg.sv | 15 +
 rtl/weight_row_buffer.sv | 27 ++
 rtl/weight_loader.sv | 166 ++++++++++++++++
 tb/tb_weight_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN accelerator datapath.
// Array geometry defaults and the weight loader state encoding.
package bnn_pkg;

  localparam int ARRAY_ROWS = 32;
  localparam int ARRAY_COLS = 32;
  localparam int ROW_IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ldr_state_t;

endpackage

// File: rtl/weight_row_buffer.sv
// ROWS x COLS weight row store: one synchronous write port and one
// asynchronous read port. Contents survive reset.
module weight_row_buffer
  import bnn_pkg::*;
#(
  parameter int ROWS  = ARRAY_ROWS,
  parameter int COLS  = ARRAY_COLS,
  parameter int IDX_W = ROW_IDX_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [COLS-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [COLS-1:0]  rdata
);

  logic [COLS-1:0] mem [ROWS];

  // Row write on an accepted stream beat.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_loader.sv
// Buffers streamed weight rows and replays them, column-masked, into
// the systolic array. Optional sticky xfer_err with WEIGHT_LOADER_ERR_EN.
module weight_loader
  import bnn_pkg::*;
#(
  parameter int ROWS  = ARRAY_ROWS,
  parameter int COLS  = ARRAY_COLS,
  parameter int IDX_W = ROW_IDX_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             weight_transfer,
  input  logic [4:0]       last_row,
  input  logic [4:0]       last_col,
  input  logic [COLS-1:0]  s_wt_data,
  input  logic             s_wt_valid,
  output logic             s_wt_ready,
  output logic [COLS-1:0]  arr_w_data,
  output logic             arr_w_valid,
  output logic [IDX_W-1:0] arr_w_row,
  output logic             arr_w_last,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   fill_count
`ifdef WEIGHT_LOADER_ERR_EN
  ,
  output logic             xfer_err
`endif
);

  localparam logic [4:0]     ROW_MAX  = 5'(ROWS - 1);
  localparam logic [4:0]     COL_MAX  = 5'(COLS - 1);
  localparam logic [IDX_W:0] FILL_MAX = (IDX_W+1)'(ROWS);

  ldr_state_t       state, state_d;
  logic [IDX_W-1:0] rd_ptr, lr_q, lr_d;
  logic [4:0]       lc_q, lc_d, lr_sat;
  logic [IDX_W:0]   fill_q;
  logic             wr_en, start, beat_last;
  logic [COLS-1:0]  rd_data, mask, beat_data;
  logic             valid_d, last_d, done_d;
  logic [IDX_W-1:0] row_d;
  logic [COLS-1:0]  data_d;

  // The done beat still belongs to the transfer, so hold off the source.
  assign s_wt_ready = (state == IDLE) && !done && (fill_q < FILL_MAX);
  assign wr_en      = s_wt_valid && s_wt_ready;
  assign start      = (state == IDLE) && weight_transfer;
  assign beat_last  = (rd_ptr == lr_q);
  assign busy       = (state != IDLE);
  assign fill_count = fill_q;

  assign lr_sat = (last_row > ROW_MAX) ? ROW_MAX : last_row;
  assign lr_d   = IDX_W'(lr_sat);
  assign lc_d   = (last_col > COL_MAX) ? COL_MAX : last_col;

  weight_row_buffer #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (fill_q[IDX_W-1:0]),
    .wdata (s_wt_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Thermometer mask: columns above the latched last column read zero.
  always_comb begin
    mask = '0;
    for (int i = 0; i < COLS; i++) mask[i] = (i <= int'(lc_q));
  end

  // Rows never written in this fill round load as zero.
  always_comb begin
    beat_data = '0;
    if ({1'b0, rd_ptr} < fill_q) beat_data = rd_data & mask;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state: pulses while busy are ignored.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (weight_transfer) state_d = LOAD;
      LOAD:    if (beat_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered array-side outputs.
  always_comb begin
    valid_d = 1'b0;
    row_d   = '0;
    data_d  = '0;
    last_d  = 1'b0;
    done_d  = (state == DONE);
    if (state == LOAD) begin
      valid_d = 1'b1;
      row_d   = rd_ptr;
      data_d  = beat_data;
      last_d  = beat_last;
    end
  end

  // Registered outputs toward the array.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      arr_w_valid <= 1'b0;
      arr_w_row   <= '0;
      arr_w_data  <= '0;
      arr_w_last  <= 1'b0;
      done        <= 1'b0;
    end else begin
      arr_w_valid <= valid_d;
      arr_w_row   <= row_d;
      arr_w_data  <= data_d;
      arr_w_last  <= last_d;
      done        <= done_d;
    end
  end

  // Transfer bounds latch, read pointer and fill counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lr_q   <= '0;
      lc_q   <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (start) begin
        lr_q   <= lr_d;
        lc_q   <= lc_d;
        rd_ptr <= '0;
      end else if (state == LOAD) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == DONE)  fill_q <= '0;
      else if (wr_en)     fill_q <= fill_q + 1'b1;
    end
  end

`ifdef WEIGHT_LOADER_ERR_EN
  logic [IDX_W:0] fill_nxt;
  logic           under;

  assign fill_nxt = fill_q + (IDX_W+1)'(wr_en);
  assign under    = (fill_nxt <= {1'b0, lr_d});

  // Sticky error: pulse while busy, or a start on an under-filled buffer.
  always_ff @(posedge clk) begin
    if (!resetn) xfer_err <= 1'b0;
    else if ((weight_transfer && busy) || (start && under))
      xfer_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader.
// Optional xfer_err checks follow WEIGHT_LOADER_ERR_EN.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        weight_transfer;
  logic [4:0]  last_row;
  logic [4:0]  last_col;
  logic [31:0] s_wt_data;
  logic        s_wt_valid;
  logic        s_wt_ready;
  logic [31:0] arr_w_data;
  logic        arr_w_valid;
  logic [4:0]  arr_w_row;
  logic        arr_w_last;
  logic        busy;
  logic        done;
  logic [5:0]  fill_count;
`ifdef WEIGHT_LOADER_ERR_EN
  logic        xfer_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_data [32];

  weight_loader dut (
    .clk             (clk),
    .resetn          (resetn),
    .weight_transfer (weight_transfer),
    .last_row        (last_row),
    .last_col        (last_col),
    .s_wt_data       (s_wt_data),
    .s_wt_valid      (s_wt_valid),
    .s_wt_ready      (s_wt_ready),
    .arr_w_data      (arr_w_data),
    .arr_w_valid     (arr_w_valid),
    .arr_w_row       (arr_w_row),
    .arr_w_last      (arr_w_last),
    .busy            (busy),
    .done            (done),
    .fill_count      (fill_count)
`ifdef WEIGHT_LOADER_ERR_EN
    ,
    .xfer_err        (xfer_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks += 8;
    if (arr_w_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset.valid got %b exp 0", arr_w_valid);
    end
    if (arr_w_data !== 32'h0) begin
      failures++;
      $display("FAIL reset.data got %h exp 0", arr_w_data);
    end
    if (arr_w_row !== 5'd0) begin
      failures++;
      $display("FAIL reset.row got %0d exp 0", arr_w_row);
    end
    if (arr_w_last !== 1'b0) begin
      failures++;
      $display("FAIL reset.last got %b exp 0", arr_w_last);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset.busy got %b exp 0", busy);
    end
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset.done got %b exp 0", done);
    end
    if (fill_count !== 6'd0) begin
      failures++;
      $display("FAIL reset.fill got %0d exp 0", fill_count);
    end
    if (s_wt_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset.ready got %b exp 1", s_wt_ready);
    end
`ifdef WEIGHT_LOADER_ERR_EN
    checks++;
    if (xfer_err !== 1'b0) begin
      failures++;
      $display("FAIL reset.err got %b exp 0", xfer_err);
    end
`endif
    resetn = 1'b1;
  endtask

  task automatic fill(input int n, input logic [31:0] val, input bit rep);
    logic [7:0]  b;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b = 8'(i);
      d = rep ? {4{b}} : val;
      s_wt_data  = d;
      s_wt_valid = 1'b1;
      if (i < 32) exp_data[i] = d;
    end
    @(negedge clk);
    s_wt_valid = 1'b0;
    checks++;
    if (fill_count !== 6'(n)) begin
      failures++;
      $display("FAIL fill.count got %0d exp %0d", fill_count, n);
    end
  endtask

  task automatic xfer(input string tag, input int lr, input int lc,
                      input int nfill, input int pulse2, input bit hold);
    int          beats, dones, row;
    logic        ev;
    logic [31:0] msk, ed;
    beats = 0;
    dones = 0;
    msk = (lc >= 31) ? 32'hFFFF_FFFF : ((32'd1 << (lc + 1)) - 32'd1);
    @(negedge clk);
    last_row = 5'(lr);
    last_col = 5'(lc);
    weight_transfer = 1'b1;
    for (int k = 1; k <= lr + 4; k++) begin
      @(negedge clk);
      if (arr_w_valid === 1'b1) beats++;
      if (done === 1'b1) dones++;
      ev = (k >= 2 && k <= lr + 2);
      checks += 4;
      if (arr_w_valid !== ev) begin
        failures++;
        $display("FAIL %s.valid k=%0d got %b exp %b", tag, k, arr_w_valid, ev);
      end
      if (done !== (k == lr + 3)) begin
        failures++;
        $display("FAIL %s.done k=%0d got %b exp %b", tag, k, done, k == lr + 3);
      end
      if (s_wt_ready !== (k == lr + 4)) begin
        failures++;
        $display("FAIL %s.ready k=%0d got %b exp %b", tag, k, s_wt_ready, k == lr + 4);
      end
      if (busy !== (k <= lr + 2)) begin
        failures++;
        $display("FAIL %s.busy k=%0d got %b exp %b", tag, k, busy, k <= lr + 2);
      end
      if (ev) begin
        row = k - 2;
        ed = (row < nfill) ? (exp_data[row] & msk) : 32'h0;
        checks += 3;
        if (arr_w_row !== 5'(row)) begin
          failures++;
          $display("FAIL %s.row k=%0d got %0d exp %0d", tag, k, arr_w_row, row);
        end
        if (arr_w_data !== ed) begin
          failures++;
          $display("FAIL %s.data row=%0d got %h exp %h", tag, row, arr_w_data, ed);
        end
        if (arr_w_last !== (row == lr)) begin
          failures++;
          $display("FAIL %s.last row=%0d got %b exp %b", tag, row, arr_w_last, row == lr);
        end
      end
      if (k == lr + 2) begin
        checks++;
        if (fill_count !== 6'(nfill)) begin
          failures++;
          $display("FAIL %s.fill_load got %0d exp %0d", tag, fill_count, nfill);
        end
      end
      if (k == lr + 3) begin
        checks++;
        if (fill_count !== 6'd0) begin
          failures++;
          $display("FAIL %s.fill_clear got %0d exp 0", tag, fill_count);
        end
      end
      weight_transfer = (k == pulse2);
      last_row = 5'(31 - k);
      last_col = 5'(k);
      if (k == 1) s_wt_valid = hold;
      if (k == lr + 2) s_wt_valid = 1'b0;
    end
    weight_transfer = 1'b0;
    checks += 2;
    if (beats != lr + 1) begin
      failures++;
      $display("FAIL %s.beats got %0d exp %0d", tag, beats, lr + 1);
    end
    if (dones != 1) begin
      failures++;
      $display("FAIL %s.dones got %0d exp 1", tag, dones);
    end
  endtask

  task automatic test_full_load();
    fill(32, 32'h0, 1'b1);
    xfer("full", 31, 31, 32, -1, 1'b0);
  endtask

  task automatic test_col_mask();
    fill(4, 32'hFFFF_FFFF, 1'b0);
    xfer("mask", 3, 7, 4, -1, 1'b0);
`ifdef WEIGHT_LOADER_ERR_EN
    checks++;
    if (xfer_err !== 1'b0) begin
      failures++;
      $display("FAIL mask.err got %b exp 0", xfer_err);
    end
`endif
  endtask

  task automatic test_underfill();
    fill(2, 32'hFFFF_FFFF, 1'b0);
    xfer("under", 5, 31, 2, -1, 1'b0);
`ifdef WEIGHT_LOADER_ERR_EN
    checks++;
    if (xfer_err !== 1'b1) begin
      failures++;
      $display("FAIL under.err got %b exp 1", xfer_err);
    end
`endif
  endtask

  task automatic test_busy_pulse();
    test_reset();
    fill(8, 32'h0, 1'b1);
    s_wt_data = 32'hDEAD_BEEF;
    xfer("busy", 7, 31, 8, 3, 1'b1);
`ifdef WEIGHT_LOADER_ERR_EN
    checks++;
    if (xfer_err !== 1'b1) begin
      failures++;
      $display("FAIL busy.err got %b exp 1", xfer_err);
    end
`endif
  endtask

  task automatic test_overfill_reset();
    logic [7:0] b;
    int         dones, beats, expf;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      expf = (i < 32) ? i : 32;
      checks += 2;
      if (s_wt_ready !== (i < 32)) begin
        failures++;
        $display("FAIL ovf.ready i=%0d got %b exp %b", i, s_wt_ready, i < 32);
      end
      if (fill_count !== 6'(expf)) begin
        failures++;
        $display("FAIL ovf.fill i=%0d got %0d exp %0d", i, fill_count, expf);
      end
      b = 8'(i);
      s_wt_data  = {4{b}};
      s_wt_valid = 1'b1;
    end
    @(negedge clk);
    s_wt_valid = 1'b0;
    checks++;
    if (fill_count !== 6'd32) begin
      failures++;
      $display("FAIL ovf.sat got %0d exp 32", fill_count);
    end
    last_row = 5'd31;
    last_col = 5'd31;
    weight_transfer = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      weight_transfer = 1'b0;
    end
    checks += 2;
    if (arr_w_valid !== 1'b1 || arr_w_row !== 5'd3) begin
      failures++;
      $display("FAIL rst.beat3 got v=%b row=%0d exp v=1 row=3", arr_w_valid, arr_w_row);
    end
    if (arr_w_data !== 32'h0303_0303) begin
      failures++;
      $display("FAIL rst.data3 got %h exp 03030303", arr_w_data);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks += 4;
    if (arr_w_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst.valid got %b exp 0", arr_w_valid);
    end
    if (fill_count !== 6'd0) begin
      failures++;
      $display("FAIL rst.fill got %0d exp 0", fill_count);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst.busy got %b exp 0", busy);
    end
    if (s_wt_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst.ready got %b exp 1", s_wt_ready);
    end
    resetn = 1'b1;
    dones = 0;
    beats = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dones++;
      if (arr_w_valid === 1'b1) beats++;
      @(negedge clk);
    end
    checks += 2;
    if (dones != 0) begin
      failures++;
      $display("FAIL rst.done got %0d pulses exp 0", dones);
    end
    if (beats != 0) begin
      failures++;
      $display("FAIL rst.beats got %0d exp 0", beats);
    end
  endtask

  initial begin
    resetn          = 1'b0;
    weight_transfer = 1'b0;
    last_row        = '0;
    last_col        = '0;
    s_wt_data       = '0;
    s_wt_valid      = 1'b0;
    test_reset();
    test_full_load();
    test_col_mask();
    test_underfill();
    test_busy_pulse();
    test_overfill_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
